umi_port_arbiter: RTL and testbench
===================================

Name: umi_port_arbiter

Overview:
- Per-output-port arbiter for the UMI crossbar; one instance per output port, N instances per crossbar.
- Selects one of N input requesters and drives the one-hot grant that steers that requester's cmd/dstaddr/srcaddr/data onto the output.
- Holds the grant for a whole multi-beat transaction, until the beat with EOM is accepted.
- Supports fixed-priority, round-robin and aged-priority policies, plus a per-requester mask.

Parameters:
- N, 4, number of requesters (input ports); N >= 2.
- AGE_MAX, 15, wait-cycle threshold for starvation escalation in aged mode; AGE_MAX >= 1.
- SW, $clog2(N), width of encoded select output (derived; do not override).

Ports:
- clk  input  1  clock.
- nreset  input  1  reset; one clock; asynchronous assert, active-low.
- mode  input  2  policy: 00 fixed priority; 01 round-robin; 10 aged priority; 11 same as 01.
- mask  input  N  1 = requester excluded from new arbitration.
- umi_in_request  input  N  requester i has a valid beat for this output.
- umi_in_eom  input  N  EOM flag of requester i's current beat.
- umi_out_ready  input  1  output sink accepts a beat.
- umi_in_grant  output  N  one-hot (or zero) grant to requesters.
- umi_out_valid  output  1  equals |(umi_in_grant & umi_in_request).
- umi_out_sel  output  SW  binary index of the granted requester; 0 when no grant.
- locked  output  1  1 while a transaction is in progress (LOCKED state).

Behaviour:
- fire = umi_out_valid & umi_out_ready; eom_fire = fire & |(umi_in_grant & umi_in_eom).
- eligible = umi_in_request & ~mask.
- State machine has two states, IDLE and LOCKED.
- IDLE:
  - umi_in_grant = arbitration result over eligible; combinational, zero-cycle latency.
  - fire & ~eom_fire -> LOCKED; grant captured in lock_q.
  - eom_fire (single-beat transaction) -> stay IDLE.
- LOCKED:
  - umi_in_grant = lock_q, independent of mask changes and of other requests.
  - eom_fire -> IDLE; the next arbitration is evaluated in the following cycle.
  - If the locked requester deasserts its request, hold the lock: umi_out_valid = 0 and no fire.
- Fixed priority: lowest eligible index wins.
- Round-robin:
  - Search eligible starting at pointer rr_q, wrapping modulo N.
  - On every eom_fire, rr_q <= (granted index + 1) mod N. rr_q is unchanged on non-EOM beats and in other modes.
- Aged priority:
  - age[i] increments each cycle that umi_in_request[i] & ~umi_in_grant[i], saturating at AGE_MAX.
  - age[i] clears when fire for i, or when umi_in_request[i] = 0.
  - Any eligible requester with age == AGE_MAX is "aged". If aged requesters exist, the lowest aged index wins; otherwise fixed priority applies.
  - Counters run in all modes; they affect the decision only in mode 10.
- Mode change takes effect at the next IDLE arbitration; it never breaks a lock.
- Zero eligible requesters in IDLE: grant = 0, umi_out_valid = 0, umi_out_sel = 0.
- Grant is always at most one-hot. umi_in_grant bits may be set without a matching request only in LOCKED.
- Reset (asynchronous, any time, including mid-transaction):
  - state = IDLE; lock_q = 0; rr_q = 0; all age = 0.
  - All outputs 0 while nreset = 0.
  - The first arbitration after release uses rr_q = 0.

Decomposition:
- Package umi_arb_pkg holds the mode encoding constants (ARB_PRIO, ARB_RR, ARB_AGED), the state enum (ARB_IDLE, ARB_LOCKED) and a onehot-to-binary function.
- One sub-module, umi_arb_rr_pick:
  - Combinational find-first-set over an N-bit vector, starting from a given index with wrap-around.
  - Used with a start index of 0 for fixed and aged priority, and with rr_q for round-robin.
- Age counters and the FSM stay in the top module.

Test Plan (N=4, AGE_MAX=3):
- Mode 00, request=4'b1010, all EOM, ready=1 -> grant 4'b0010 for each cycle while request stays; port 3 is never granted.
- Mode 01, request=4'b1111 constant, single-beat EOM traffic -> grant sequence 0001, 0010, 0100, 1000, 0001; sel sequence 0,1,2,3,0.
- Mode 01, port 1 sends 3 beats (EOM on beat 3) while ports 0 and 2 request; ready toggles 1,0,1,1:
  - grant stays 0010 until the EOM beat is accepted, with locked=1 throughout;
  - the next grant goes to port 2, not port 0.
- Mode 10, port 0 continuous single-beat traffic, port 3 requesting -> port 3 granted in the cycle after its age reaches 3, then its age clears to 0.
- Mask 4'b0010 asserted mid-lock on port 1 -> lock is held to EOM; port 1 is not regranted while the mask is set.
- nreset asserted mid-transaction with locked=1 -> grant, valid and locked go to 0 immediately; after release, request=4'b1100 in mode 01 -> grant 0100.

Source files
------------

// File: rtl/umi_port_arbiter_pkg.sv
// Shared encodings for the UMI per-output-port arbiter.
package umi_arb_pkg;

  localparam logic [1:0] ARB_PRIO = 2'b00;
  localparam logic [1:0] ARB_RR   = 2'b01;
  localparam logic [1:0] ARB_AGED = 2'b10;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Binary index of a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned oh2bin(input logic [31:0] oh);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < 32; i++)
      if (oh[i]) b = b | i;
    return b;
  endfunction

endpackage

// File: rtl/umi_port_arbiter_if.sv
// Request/grant bundle between N requesters, one output sink and the arbiter.
interface umi_port_arbiter_if #(parameter int N = 4);
  localparam int SW = $clog2(N);

  logic [1:0]    mode;
  logic [N-1:0]  mask;
  logic [N-1:0]  umi_in_request;
  logic [N-1:0]  umi_in_eom;
  logic          umi_out_ready;
  logic [N-1:0]  umi_in_grant;
  logic          umi_out_valid;
  logic [SW-1:0] umi_out_sel;
  logic          locked;

  modport slave (
    input  mode, mask, umi_in_request, umi_in_eom, umi_out_ready,
    output umi_in_grant, umi_out_valid, umi_out_sel, locked
  );

  modport master (
    output mode, mask, umi_in_request, umi_in_eom, umi_out_ready,
    input  umi_in_grant, umi_out_valid, umi_out_sel, locked
  );
endinterface

// File: rtl/umi_port_arbiter_rr_pick.sv
// Find-first-set over vec_i starting at start_i, wrapping modulo N; one-hot out.
module umi_arb_rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [SW-1:0] start_i,
  output logic [N-1:0]  oh_o
);

  // Walk from the farthest candidate back to start so the nearest one wins.
  always_comb begin
    oh_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int            idx;
      logic [SW-1:0] pos;
      idx = int'(start_i) + k;
      if (idx >= N) idx = idx - N;
      pos = SW'(idx);
      if (vec_i[pos]) begin
        oh_o      = '0;
        oh_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umi_port_arbiter.sv
// Per-output-port UMI arbiter: fixed / round-robin / aged policy, grant held to EOM.
module umi_port_arbiter
  import umi_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int AGE_MAX = 15,
  parameter int SW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            nreset,
  umi_port_arbiter_if.slave bus
);

  localparam int AW = $clog2(AGE_MAX + 1);

  arb_state_e             state_q, state_d;
  logic [N-1:0]           lock_q, lock_d;
  logic [SW-1:0]          rr_q, rr_d;
  logic [N-1:0][AW-1:0]   age_q;

  logic [N-1:0]  eligible, aged, pick_vec, pick_oh, grant;
  logic [SW-1:0] start, sel;
  logic          valid, fire, eom_fire;

  assign eligible = bus.umi_in_request & ~bus.mask;

  always_comb begin
    for (int i = 0; i < N; i++)
      aged[i] = eligible[i] && (age_q[i] == AW'(AGE_MAX));
  end

  // Aged mode narrows the candidate set to starving requesters when any exist.
  always_comb begin
    pick_vec = eligible;
    start    = '0;
    case (bus.mode)
      ARB_PRIO: ;
      ARB_AGED: if (|aged) pick_vec = aged;
      default:  start = rr_q;
    endcase
  end

  umi_arb_rr_pick #(.N(N), .SW(SW)) u_pick (
    .vec_i   (pick_vec),
    .start_i (start),
    .oh_o    (pick_oh)
  );

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    grant   = '0;
    if (nreset) grant = (state_q == ARB_LOCKED) ? lock_q : pick_oh;
    valid    = |(grant & bus.umi_in_request);
    fire     = valid & bus.umi_out_ready;
    eom_fire = fire & (|(grant & bus.umi_in_eom));
    case (state_q)
      ARB_IDLE: if (fire && !eom_fire) begin
        state_d = ARB_LOCKED;
        lock_d  = grant;
      end
      ARB_LOCKED: if (eom_fire) begin
        state_d = ARB_IDLE;
        lock_d  = '0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign sel = SW'(oh2bin(32'(grant)));

  always_comb begin
    rr_d = rr_q;
    if (eom_fire && (bus.mode == ARB_RR || bus.mode == 2'b11))
      rr_d = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ARB_IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
    end
  end

  // Ages track waiting in every mode so a switch to aged mode sees real history.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!bus.umi_in_request[i] || (fire && grant[i]))
          age_q[i] <= '0;
        else if (!grant[i] && age_q[i] != AW'(AGE_MAX))
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  assign bus.umi_in_grant  = grant;
  assign bus.umi_out_valid = valid;
  assign bus.umi_out_sel   = sel;
  assign bus.locked        = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_umi_port_arbiter.sv
// Directed scoreboard bench for umi_port_arbiter (N=4, AGE_MAX=3).
module tb_umi_port_arbiter;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  umi_port_arbiter_if #(.N(4)) bus ();

  umi_port_arbiter #(.N(4), .AGE_MAX(3)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] g;
    logic       v;
    logic [1:0] s;
    logic       l;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs just after the edge and queue the expected outputs.
  task automatic step(input logic rn, input logic [1:0] md, input logic [3:0] mk,
                      input logic [3:0] rq, input logic [3:0] eo, input logic rdy,
                      input logic [3:0] g, input logic v, input logic [1:0] s,
                      input logic l, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    nreset             = rn;
    bus.mode           = md;
    bus.mask           = mk;
    bus.umi_in_request = rq;
    bus.umi_in_eom     = eo;
    bus.umi_out_ready  = rdy;
    e.g = g; e.v = v; e.s = s; e.l = l; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({bus.umi_in_grant, bus.umi_out_valid, bus.umi_out_sel, bus.locked} !==
            {e.g, e.v, e.s, e.l}) begin
          n_bad++;
          $display("FAIL %s: got grant=%b valid=%b sel=%0d locked=%b, want grant=%b valid=%b sel=%0d locked=%b",
                   e.nm, bus.umi_in_grant, bus.umi_out_valid, bus.umi_out_sel, bus.locked,
                   e.g, e.v, e.s, e.l);
        end
      end
    end
  end

  initial begin : stim
    bus.mode = 2'b00; bus.mask = '0; bus.umi_in_request = '0;
    bus.umi_in_eom = '0; bus.umi_out_ready = 1'b0;

    // Outputs held at zero while reset is asserted, even with requests present.
    step(0, 2'b00, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0000, 0, 2'd0, 0, "rst_hold");

    // Fixed priority: port 1 always beats port 3.
    for (int i = 0; i < 3; i++)
      step(1, 2'b00, 4'b0000, 4'b1010, 4'b1111, 1, 4'b0010, 1, 2'd1, 0, "prio_1010");

    // Round-robin rotation from rr=0.
    step(1, 2'b01, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd0, 0, "rr_0");
    step(1, 2'b01, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0010, 1, 2'd1, 0, "rr_1");
    step(1, 2'b01, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2'd2, 0, "rr_2");
    step(1, 2'b01, 4'b0000, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2'd3, 0, "rr_3");
    step(1, 2'b01, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd0, 0, "rr_wrap");

    // Three-beat burst on port 1 with a ready stall; next grant goes past port 1.
    step(1, 2'b01, 4'b0000, 4'b0111, 4'b0000, 1, 4'b0010, 1, 2'd1, 0, "burst_b1");
    step(1, 2'b01, 4'b0000, 4'b0111, 4'b0000, 0, 4'b0010, 1, 2'd1, 1, "burst_stall");
    step(1, 2'b01, 4'b0000, 4'b0111, 4'b0000, 1, 4'b0010, 1, 2'd1, 1, "burst_b2");
    step(1, 2'b01, 4'b0000, 4'b0111, 4'b0010, 1, 4'b0010, 1, 2'd1, 1, "burst_b3eom");
    step(1, 2'b01, 4'b0000, 4'b0101, 4'b0101, 1, 4'b0100, 1, 2'd2, 0, "burst_next");

    // Idle cycle clears every age counter.
    step(1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, "idle_none");

    // Aged: port 3 waits three cycles behind port 0, then wins once.
    step(1, 2'b10, 4'b0000, 4'b1001, 4'b1001, 1, 4'b0001, 1, 2'd0, 0, "aged_w0");
    step(1, 2'b10, 4'b0000, 4'b1001, 4'b1001, 1, 4'b0001, 1, 2'd0, 0, "aged_w1");
    step(1, 2'b10, 4'b0000, 4'b1001, 4'b1001, 1, 4'b0001, 1, 2'd0, 0, "aged_w2");
    step(1, 2'b10, 4'b0000, 4'b1001, 4'b1001, 1, 4'b1000, 1, 2'd3, 0, "aged_win");
    step(1, 2'b10, 4'b0000, 4'b1001, 4'b1001, 1, 4'b0001, 1, 2'd0, 0, "aged_clear");

    // Mask mid-lock: lock survives, request drop stalls, no regrant after EOM.
    step(1, 2'b00, 4'b0000, 4'b0110, 4'b0000, 1, 4'b0010, 1, 2'd1, 0, "mask_start");
    step(1, 2'b00, 4'b0010, 4'b0110, 4'b0000, 1, 4'b0010, 1, 2'd1, 1, "mask_held");
    step(1, 2'b00, 4'b0010, 4'b0100, 4'b0000, 1, 4'b0010, 0, 2'd1, 1, "lock_req_drop");
    step(1, 2'b00, 4'b0010, 4'b0110, 4'b0010, 1, 4'b0010, 1, 2'd1, 1, "mask_eom");
    step(1, 2'b00, 4'b0010, 4'b0110, 4'b0110, 1, 4'b0100, 1, 2'd2, 0, "mask_excl_a");
    step(1, 2'b00, 4'b0010, 4'b0110, 4'b0110, 1, 4'b0100, 1, 2'd2, 0, "mask_excl_b");

    // Reset mid-transaction, then rr restarts at 0.
    step(1, 2'b01, 4'b0000, 4'b1100, 4'b0000, 1, 4'b1000, 1, 2'd3, 0, "pre_rst_grant");
    step(1, 2'b01, 4'b0000, 4'b1100, 4'b0000, 1, 4'b1000, 1, 2'd3, 1, "pre_rst_lock");
    step(0, 2'b01, 4'b0000, 4'b1100, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, "rst_midlock");
    step(1, 2'b01, 4'b0000, 4'b1100, 4'b1100, 1, 4'b0100, 1, 2'd2, 0, "post_rst_rr");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
